// File: rtl/wb_scheduler.sv
// Write-back port arbiter between the pipeline WB stage and the mul/div unit, with a pending-write scoreboard for decode hazards.
// Optional statistics counters are enabled by defining WB_SCHED_STATS_EN.
module wb_scheduler #(
    parameter int unsigned STARVE_LIMIT    = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_wb_en,
    input  logic [4:0]  pipe_wb_addr,
    input  logic [31:0] pipe_wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_addr,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_we,
    input  logic        id_is_md,
    output logic        issue_stall,
    output logic        hold_pipe,
`ifdef WB_SCHED_STATS_EN
    output logic [15:0] stat_conflicts,
    output logic [15:0] stat_forced,
`endif
    output logic        reg_write,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data
);

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
    localparam logic [3:0] MAX_OUT_C    = 4'(MAX_OUTSTANDING);

    logic [31:0] pending_q, pending_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [3:0]  starve_q, starve_d;

    logic        pipe_req_s, md_req_s, force_s;
    logic        md_grant_s, pipe_grant_s;
    logic [31:0] set_mask_s, clr_mask_s;

    // Arbitration for the single register-file write port.
    always_comb begin
        pipe_req_s   = pipe_wb_en && (pipe_wb_addr != 5'd0);
        md_req_s     = md_valid && (md_addr != 5'd0);
        force_s      = (starve_q == STARVE_LIM_C) && md_req_s;
        md_grant_s   = 1'b0;
        pipe_grant_s = 1'b0;
        md_ready     = 1'b0;
        hold_pipe    = 1'b0;
        if (reset) begin
            md_ready = 1'b0;
        end else if (md_valid && (md_addr == 5'd0)) begin
            // A result for x0 is simply drained; the port stays free for WB.
            md_ready     = 1'b1;
            pipe_grant_s = pipe_req_s;
        end else if (force_s) begin
            md_grant_s = 1'b1;
            md_ready   = 1'b1;
            hold_pipe  = 1'b1;
        end else if (pipe_req_s) begin
            pipe_grant_s = 1'b1;
        end else begin
            md_ready   = md_valid;
            md_grant_s = md_valid;
        end
    end

    // Register-file write port mux.
    always_comb begin
        reg_write  = 1'b0;
        write_addr = 5'd0;
        write_data = 32'd0;
        if (md_grant_s) begin
            reg_write  = 1'b1;
            write_addr = md_addr;
            write_data = md_data;
        end else if (pipe_grant_s) begin
            reg_write  = 1'b1;
            write_addr = pipe_wb_addr;
            write_data = pipe_wb_data;
        end else begin
            reg_write  = 1'b0;
        end
    end

    // Next-state for the starve counter, scoreboard and outstanding count.
    always_comb begin
        starve_d = starve_q;
        if (md_ready) begin
            starve_d = 4'd0;
        end else if (md_req_s && (starve_q != STARVE_LIM_C)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        set_mask_s = 32'd0;
        clr_mask_s = 32'd0;
        if (md_issue && (md_issue_addr != 5'd0)) begin
            set_mask_s = 32'd1 << md_issue_addr;
        end else begin
            set_mask_s = 32'd0;
        end
        if (md_ready && (md_addr != 5'd0)) begin
            clr_mask_s = 32'd1 << md_addr;
        end else begin
            clr_mask_s = 32'd0;
        end
        // Set after clear so a reissue to the same register stays outstanding.
        pending_d = ((pending_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

        outstanding_d = outstanding_q;
        case ({md_issue, md_ready && md_valid})
            2'b10: begin
                if (outstanding_q != MAX_OUT_C) begin
                    outstanding_d = outstanding_q + 4'd1;
                end else begin
                    outstanding_d = outstanding_q;
                end
            end
            2'b01: begin
                if (outstanding_q != 4'd0) begin
                    outstanding_d = outstanding_q - 4'd1;
                end else begin
                    outstanding_d = outstanding_q;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Decode hazard detection against registered scoreboard state.
    always_comb begin
        issue_stall = 1'b0;
        if (reset) begin
            issue_stall = 1'b0;
        end else begin
            issue_stall = pending_q[id_rs1] || pending_q[id_rs2] ||
                          (id_rd_we && pending_q[id_rd]) ||
                          (id_is_md && (outstanding_q == MAX_OUT_C));
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q     <= 32'd0;
            outstanding_q <= 4'd0;
            starve_q      <= 4'd0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            starve_q      <= starve_d;
        end
    end

`ifdef WB_SCHED_STATS_EN
    logic [15:0] stat_conflicts_q, stat_conflicts_d;
    logic [15:0] stat_forced_q, stat_forced_d;

    // Saturating statistics counters.
    always_comb begin
        stat_conflicts_d = stat_conflicts_q;
        stat_forced_d    = stat_forced_q;
        if (pipe_req_s && md_req_s && (stat_conflicts_q != 16'hFFFF)) begin
            stat_conflicts_d = stat_conflicts_q + 16'd1;
        end else begin
            stat_conflicts_d = stat_conflicts_q;
        end
        if (force_s && (stat_forced_q != 16'hFFFF)) begin
            stat_forced_d = stat_forced_q + 16'd1;
        end else begin
            stat_forced_d = stat_forced_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_conflicts_q <= 16'd0;
            stat_forced_q    <= 16'd0;
        end else begin
            stat_conflicts_q <= stat_conflicts_d;
            stat_forced_q    <= stat_forced_d;
        end
    end

    assign stat_conflicts = stat_conflicts_q;
    assign stat_forced    = stat_forced_q;
`endif

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed self-checking bench for wb_scheduler (STARVE_LIMIT=4, MAX_OUTSTANDING=2).
module tb_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rd_we, id_is_md;
    logic        issue_stall, hold_pipe, reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int checks   = 0;
    int failures = 0;

    wb_scheduler #(.STARVE_LIMIT(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .pipe_wb_en(pipe_wb_en), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .md_issue(md_issue), .md_issue_addr(md_issue_addr),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_md(id_is_md),
        .issue_stall(issue_stall), .hold_pipe(hold_pipe),
        .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1;
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd5; pipe_wb_data = 32'h1111_1111;
        md_valid = 1'b1; md_addr = 5'd6; md_data = 32'h2222_2222;
        md_issue = 1'b0; md_issue_addr = 5'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_rd_we = 1'b0; id_is_md = 1'b1;
        settle();
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
        chk("rst_hold_pipe", {31'd0, hold_pipe}, 32'd0);
        chk("rst_issue_stall", {31'd0, issue_stall}, 32'd0);
        chk("rst_write_addr", {27'd0, write_addr}, 32'd0);
        tick();
        tick();
        reset = 1'b0; md_valid = 1'b0; id_is_md = 1'b0;
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd5; pipe_wb_data = 32'hDEAD_BEEF;
        settle();
        chk("solo_reg_write", {31'd0, reg_write}, 32'd1);
        chk("solo_addr", {27'd0, write_addr}, 32'd5);
        chk("solo_data", write_data, 32'hDEAD_BEEF);
        chk("solo_md_ready", {31'd0, md_ready}, 32'd0);

        // Conflict: pipe wins, md follows once WB goes idle.
        tick();
        pipe_wb_addr = 5'd3; pipe_wb_data = 32'h3333_3333;
        md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h7777_7777;
        settle();
        chk("conf_addr", {27'd0, write_addr}, 32'd3);
        chk("conf_md_ready", {31'd0, md_ready}, 32'd0);
        tick();
        pipe_wb_en = 1'b0;
        settle();
        chk("conf_md_ready2", {31'd0, md_ready}, 32'd1);
        chk("conf_addr2", {27'd0, write_addr}, 32'd7);
        chk("conf_data2", write_data, 32'h7777_7777);

        // Starvation: four denials, forced grant on the fifth cycle.
        tick();
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd2; pipe_wb_data = 32'h2222_0002;
        md_addr = 5'd9; md_data = 32'h9999_9999;
        settle();
        chk("starve_ready_0", {31'd0, md_ready}, 32'd0);
        chk("starve_addr_0", {27'd0, write_addr}, 32'd2);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("starve_ready_n", {31'd0, md_ready}, 32'd0);
            chk("starve_hold_n", {31'd0, hold_pipe}, 32'd0);
        end
        tick();
        chk("force_hold", {31'd0, hold_pipe}, 32'd1);
        chk("force_ready", {31'd0, md_ready}, 32'd1);
        chk("force_addr", {27'd0, write_addr}, 32'd9);
        chk("force_data", write_data, 32'h9999_9999);
        tick();
        md_valid = 1'b0;
        settle();
        chk("held_hold", {31'd0, hold_pipe}, 32'd0);
        chk("held_addr", {27'd0, write_addr}, 32'd2);
        chk("held_data", write_data, 32'h2222_0002);

        // RAW / WAW against an outstanding mul/div result.
        tick();
        pipe_wb_en = 1'b0;
        md_issue = 1'b1; md_issue_addr = 5'd12; id_rs2 = 5'd12;
        settle();
        chk("raw_same_cycle", {31'd0, issue_stall}, 32'd0);
        tick();
        md_issue = 1'b0;
        settle();
        chk("raw_stall", {31'd0, issue_stall}, 32'd1);
        tick();
        id_rs2 = 5'd0; id_rd = 5'd12; id_rd_we = 1'b1;
        settle();
        chk("waw_stall", {31'd0, issue_stall}, 32'd1);
        id_rd_we = 1'b0;
        settle();
        chk("rd_no_we", {31'd0, issue_stall}, 32'd0);
        id_rs2 = 5'd12;
        tick();
        md_valid = 1'b1; md_addr = 5'd12; md_data = 32'h0000_00CC;
        settle();
        chk("raw_accept_ready", {31'd0, md_ready}, 32'd1);
        chk("raw_accept_addr", {27'd0, write_addr}, 32'd12);
        chk("raw_accept_stall", {31'd0, issue_stall}, 32'd1);
        tick();
        md_valid = 1'b0;
        settle();
        chk("raw_cleared", {31'd0, issue_stall}, 32'd0);

        // Outstanding limit with x0 destinations.
        tick();
        id_rs2 = 5'd0; id_is_md = 1'b1;
        md_issue = 1'b1; md_issue_addr = 5'd0;
        settle();
        chk("out_0", {31'd0, issue_stall}, 32'd0);
        tick();
        chk("out_1", {31'd0, issue_stall}, 32'd0);
        tick();
        md_issue = 1'b0;
        settle();
        chk("out_full", {31'd0, issue_stall}, 32'd1);
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'h0BAD_0BAD;
        settle();
        chk("x0_ready", {31'd0, md_ready}, 32'd1);
        chk("x0_no_write", {31'd0, reg_write}, 32'd0);
        tick();
        md_valid = 1'b0;
        settle();
        chk("out_released", {31'd0, issue_stall}, 32'd0);

        // Set and clear of the same register in one cycle.
        tick();
        id_is_md = 1'b0;
        md_issue = 1'b1; md_issue_addr = 5'd4;
        md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h4444_4444;
        settle();
        chk("coll_ready", {31'd0, md_ready}, 32'd1);
        chk("coll_addr", {27'd0, write_addr}, 32'd4);
        tick();
        md_issue = 1'b0; md_valid = 1'b0; id_rs1 = 5'd4;
        settle();
        chk("coll_pending", {31'd0, issue_stall}, 32'd1);

        // Reset mid-operation discards the scoreboard.
        tick();
        reset = 1'b1; md_valid = 1'b1; md_addr = 5'd8;
        settle();
        chk("midrst_stall", {31'd0, issue_stall}, 32'd0);
        chk("midrst_ready", {31'd0, md_ready}, 32'd0);
        tick();
        reset = 1'b0; md_valid = 1'b0;
        settle();
        chk("postrst_stall", {31'd0, issue_stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
